rf_wr_arbiter: RTL
==================

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Reset rst SHALL be asynchronous, active-low; clock clk SHALL be the only clock.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  3  per-requester write request; bit 0 ALU, bit 1 LSU, bit 2 DBG.
REQ-005 req_addr  input  15  three 5-bit destination register indices; requester i at bits [5i+4:5i].
REQ-006 req_data  input  96  three 32-bit write values; requester i at bits [32i+31:32i].
REQ-007 req_ready  output  3  one-hot-or-zero grant; a transfer on requester i is req_valid[i] & req_ready[i].
REQ-008 claim_valid  input  1  issue stage marks a register as having a load in flight.
REQ-009 claim_addr  input  5  register index being claimed.
REQ-010 busy  output  32  per-register pending-load scoreboard.
REQ-011 waddr / wdata / regwen  output  5 / 32 / 1  registered write port driving the register file.

Function
REQ-012 Each cycle, at most one req_ready bit SHALL be high, and only for a requester with req_valid set; req_ready SHALL be combinational from req_valid and the arbitration state.
REQ-013 The default (fixed) priority SHALL be LSU > ALU > DBG.
REQ-014 On a transfer, waddr/wdata SHALL take the granted address/data at the next rising edge, and regwen SHALL be 1 for exactly that cycle; latency is one cycle.
REQ-015 regwen SHALL be 0 in any cycle following a cycle with no transfer; waddr/wdata SHALL hold their previous values.
REQ-016 A transfer to address 0 SHALL be accepted (ready asserted) but SHALL produce regwen = 0.
REQ-017 A claim with claim_addr != 0 SHALL set busy[claim_addr] at the next edge; a claim of x0 SHALL be ignored; busy[0] SHALL always read 0.
REQ-018 An LSU transfer to register r SHALL clear busy[r] at the next edge; ALU and DBG transfers SHALL NOT modify busy.
REQ-019 When a claim and an LSU clear target the same register in the same cycle, set SHALL win (busy stays 1).
REQ-020 Claiming an already-busy register SHALL leave it busy; there is no count, so a single clear releases it.
REQ-021 An unselected requester SHALL hold its request; the block SHALL NOT drop requests, and there is no internal queue.

Reset
REQ-022 While rst = 0: regwen = 0, waddr = 0, wdata = 0, busy = 0, and the round-robin pointer = 0 (when compiled in); req_ready SHALL be 0.
REQ-023 Reset asserted mid-operation SHALL discard any pending registered write, so no regwen pulse follows reset deassertion.

Configuration
REQ-024 Macro RF_ARB_RR_EN SHALL select the arbitration policy.
- Defined: round-robin; after a grant to requester i, search starts at (i+1) mod 3.
- Not defined: fixed priority per REQ-013, with no pointer state.

Structure
REQ-025 Package rf_pkg SHALL hold NUM_REQ = 3, requester indices REQ_ALU/REQ_LSU/REQ_DBG, reg_idx_t (5-bit) and xlen_t (32-bit).
REQ-026 Arbitration SHALL be a sub-module rf_arb_sel (valid vector + pointer in, one-hot grant out); the scoreboard and output register SHALL live in rf_wr_arbiter.

Verification
REQ-027 Reset: hold rst = 0 with all req_valid = 1 -> req_ready = 0, regwen = 0, busy = 0; release -> first grant goes to LSU in either configuration.
REQ-028 Simultaneous ALU(x5, 0x11) + LSU(x6, 0x22), fixed priority -> cycle 1 waddr = 6, wdata = 0x22, regwen = 1; cycle 2 waddr = 5, wdata = 0x11, regwen = 1.
REQ-029 RF_ARB_RR_EN with all three requesters valid for 6 cycles -> grant order LSU, DBG, ALU, LSU, DBG, ALU.
REQ-030 Claim x7, then LSU write x7 = 0xDEADBEEF -> busy[7] = 1 after the claim, 0 after the write; regwen pulses with waddr = 7.
REQ-031 Claim x9 in the same cycle as an LSU write to x9 -> busy[9] = 1 and regwen = 1; claim x0 -> busy = 0.
REQ-032 ALU write x0 = 0xFFFFFFFF -> req_ready[0] = 1, next-cycle regwen = 0.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and requester indices for the register-file write arbiter
package rf_pkg;

  localparam int NUM_REQ = 3;
  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_DBG = 2;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] xlen_t;
  typedef logic [1:0]  req_idx_t;

  function automatic req_idx_t onehot_idx(input logic [NUM_REQ-1:0] oh);
    req_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = req_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rf_arb_sel.sv
// rtl/rf_arb_sel.sv - one-hot grant select; RF_ARB_RR_EN picks round-robin, otherwise fixed LSU > ALU > DBG
module rf_arb_sel
  import rf_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  req_idx_t           last,
  output logic [NUM_REQ-1:0] grant
);

`ifdef RF_ARB_RR_EN
  // last holds the previous winner, so the search begins just after it
  always_comb begin
    int c;
    grant = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (int'(last) + k) % NUM_REQ;
      if (valid[req_idx_t'(c)] && (grant == '0)) grant[req_idx_t'(c)] = 1'b1;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    grant = '0;
    if (valid[REQ_LSU])      grant[REQ_LSU] = 1'b1;
    else if (valid[REQ_ALU]) grant[REQ_ALU] = 1'b1;
    else if (valid[REQ_DBG]) grant[REQ_DBG] = 1'b1;
  end
`endif

endmodule

// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - register-file write arbiter with pending-load scoreboard; RF_ARB_RR_EN enables round-robin
module rf_wr_arbiter
  import rf_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [5*NUM_REQ-1:0]   req_addr,
  input  logic [32*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   claim_valid,
  input  reg_idx_t               claim_addr,
  output logic [31:0]            busy,
  output reg_idx_t               waddr,
  output xlen_t                  wdata,
  output logic                   regwen
);

  logic [NUM_REQ-1:0] grant;
  req_idx_t           ptr;
  req_idx_t           gidx;
  logic               xfer;
  reg_idx_t           gaddr;
  xlen_t              gdata;
  logic [31:0]        busy_next;

`ifdef RF_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      ptr <= '0;
    else if (xfer) ptr <= gidx;
  end
`else
  assign ptr = '0;
`endif

  rf_arb_sel u_sel (
    .valid (req_valid),
    .last  (ptr),
    .grant (grant)
  );

  // grants never escape while reset is held
  assign req_ready = grant & {NUM_REQ{rst}};
  assign xfer      = |req_ready;
  assign gidx      = onehot_idx(req_ready);

  always_comb begin
    gaddr = req_addr[4:0];
    gdata = req_data[31:0];
    case (gidx)
      2'd1:    begin gaddr = req_addr[9:5];   gdata = req_data[63:32]; end
      2'd2:    begin gaddr = req_addr[14:10]; gdata = req_data[95:64]; end
      default: begin gaddr = req_addr[4:0];   gdata = req_data[31:0];  end
    endcase
  end

  // clear first so a same-cycle claim of the same register wins
  always_comb begin
    busy_next = busy;
    if (req_ready[REQ_LSU]) busy_next[gaddr] = 1'b0;
    if (claim_valid && (claim_addr != '0)) busy_next[claim_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy   <= '0;
      waddr  <= '0;
      wdata  <= '0;
      regwen <= 1'b0;
    end else begin
      busy   <= busy_next;
      regwen <= xfer && (gaddr != '0);
      if (xfer) begin
        waddr <= gaddr;
        wdata <= gdata;
      end
    end
  end

endmodule
